ssd_scan_ctrl: RTL

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Display updates are double-buffered and applied only at frame boundaries.
module ssd_scan_ctrl #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [3:0]  nib,
    output logic        load_ack,
    output logic        frame_done
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [15:0]   disp;
    logic [15:0]   shadow;
    logic          pending;
    logic          tick;
    logic          boundary;
    logic          lz;
    logic          off;
    logic [3:0]    sel;
    logic [3:0]    an_next;

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (dig == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            dig <= dig + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A load coinciding with the boundary bypasses the shadow entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp     <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= boundary && (load || pending);
            if (load)
                shadow <= value;
            if (boundary) begin
                pending <= 1'b0;
                if (load)
                    disp <= value;
                else if (pending)
                    disp <= shadow;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_done <= 1'b0;
        else
            frame_done <= boundary;
    end

    always_comb begin
        lz  = 1'b0;
        sel = disp[3:0];
        unique case (dig)
            2'd0: sel = disp[3:0];
            2'd1: begin
                sel = disp[7:4];
                lz  = (disp[15:4] == 12'h000);
            end
            2'd2: begin
                sel = disp[11:8];
                lz  = (disp[15:8] == 8'h00);
            end
            2'd3: begin
                sel = disp[15:12];
                lz  = (disp[15:12] == 4'h0);
            end
        endcase
        off     = blank || (lz_blank && lz);
        an_next = off ? 4'b1111 : ~(4'b0001 << dig);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            nib <= 4'h0;
        end else begin
            an  <= an_next;
            nib <= sel;
        end
    end

endmodule
